ifu_fetch: RTL and testbench

- Instruction fetch unit of the single-issue RV32 core; sits between the instruction-memory request/response interface and the EXU.
- Generates the fetch PC, issues one fetch request at a time and holds the returned instruction in a one-entry IR register.
- Presents the held instruction to the EXU with valid/ready handshake.
- Statically predicts control flow: JAL/JALR are resolved locally; conditional branches use a backward-taken rule.

---
 rtl/ifu_fetch_if.sv | 34 +++
 rtl/ifu_fetch.sv | 122 ++++++++++++
 tb/tb_ifu_fetch.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response and the IR handoff to the EXU.
// master = IFU side, slave = memory/EXU side.
interface ifu_fetch_if #(
  parameter int PC_SIZE     = 32,
  parameter int INSTR_SIZE  = 32,
  parameter int RFIDX_WIDTH = 5
);
  logic                   ifu_req_valid;
  logic                   ifu_req_ready;
  logic [PC_SIZE-1:0]     ifu_req_pc;
  logic                   ifu_rsp_valid;
  logic                   ifu_rsp_ready;
  logic [INSTR_SIZE-1:0]  ifu_rsp_instr;
  logic [INSTR_SIZE-1:0]  ifu_o_ir;
  logic [PC_SIZE-1:0]     ifu_o_pc;
  logic [RFIDX_WIDTH-1:0] ifu_o_rs1idx;
  logic [RFIDX_WIDTH-1:0] ifu_o_rs2idx;
  logic                   ifu_o_prdt_taken;
  logic                   ifu_o_valid;
  logic                   ifu_o_ready;
  logic                   ifu_o_pc_vld;

  modport master (
    output ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
           ifu_o_ir, ifu_o_pc, ifu_o_rs1idx, ifu_o_rs2idx, ifu_o_prdt_taken, ifu_o_valid, ifu_o_pc_vld,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_o_ready
  );

  modport slave (
    input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
           ifu_o_ir, ifu_o_pc, ifu_o_rs1idx, ifu_o_rs2idx, ifu_o_prdt_taken, ifu_o_valid, ifu_o_pc_vld,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_o_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// RV32 instruction fetch: one outstanding request, one-entry IR, static prediction
// (JAL/JALR resolved locally, backward conditional branches predicted taken).
module ifu_fetch #(
  parameter int PC_SIZE     = 32,
  parameter int INSTR_SIZE  = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int XLEN        = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_SIZE-1:0] inspect_pc,
  input  logic [PC_SIZE-1:0] pc_rtvec,
  input  logic [XLEN-1:0]    rf2ifu_x1,
  input  logic [XLEN-1:0]    rf2ifu_rs1,
  ifu_fetch_if.master        ifu
);
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  typedef enum logic [1:0] {S_REQ, S_RSP, S_JALR} state_t;

  state_t                 state, state_nxt;
  logic [PC_SIZE-1:0]     pc, pc_nxt, ir_pc, jalr_tgt;
  logic [INSTR_SIZE-1:0]  ir, ins;
  logic                   ir_valid, prdt_taken, prdt_nxt;
  logic                   rsp_fire, o_fire;
  logic [XLEN-1:0]        base;
  logic signed [20:0]     j_imm;
  logic signed [12:0]     b_imm;
  logic signed [11:0]     i_imm;

  assign ins      = ifu.ifu_rsp_instr;
  assign j_imm    = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign b_imm    = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign i_imm    = ir[31:20];
  assign rsp_fire = ifu.ifu_rsp_valid & ifu.ifu_rsp_ready;
  assign o_fire   = ir_valid & ifu.ifu_o_ready;

  // JALR base comes from the regfile before the JALR itself retires, so rd==rs1 is safe
  always_comb begin
    base = rf2ifu_rs1;
    if (ir[19:15] == 5'd0)      base = '0;
    else if (ir[19:15] == 5'd1) base = rf2ifu_x1;
  end
  assign jalr_tgt = (PC_SIZE'(base) + PC_SIZE'(i_imm)) & ~PC_SIZE'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    prdt_nxt  = 1'b0;
    case (state)
      S_REQ: if (ifu.ifu_req_ready) state_nxt = S_RSP;
      S_RSP: if (rsp_fire) begin
        state_nxt = S_REQ;
        pc_nxt    = pc + PC_SIZE'(4);
        case (ins[6:0])
          OP_JAL: begin
            pc_nxt   = pc + PC_SIZE'(j_imm);
            prdt_nxt = 1'b1;
          end
          OP_BR: if (b_imm[12]) begin
            pc_nxt   = pc + PC_SIZE'(b_imm);
            prdt_nxt = 1'b1;
          end
          OP_JALR: begin
            pc_nxt    = pc;
            prdt_nxt  = 1'b1;
            state_nxt = S_JALR;
          end
          default: ;
        endcase
      end
      S_JALR: if (o_fire) begin
        pc_nxt    = jalr_tgt;
        state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    ifu.ifu_req_valid = (state == S_REQ);
    ifu.ifu_rsp_ready = (state == S_RSP) & (~ir_valid | ifu.ifu_o_ready);
  end

  // a response load in the same cycle as an EXU handoff keeps ir_valid set
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= pc_rtvec;
      ir         <= '0;
      ir_pc      <= '0;
      ir_valid   <= 1'b0;
      prdt_taken <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (rsp_fire) begin
        ir         <= ins;
        ir_pc      <= pc;
        ir_valid   <= 1'b1;
        prdt_taken <= prdt_nxt;
      end else if (o_fire) begin
        ir_valid <= 1'b0;
      end
    end
  end

  assign inspect_pc           = pc;
  assign ifu.ifu_req_pc       = pc;
  assign ifu.ifu_o_ir         = ir;
  assign ifu.ifu_o_pc         = ir_pc;
  assign ifu.ifu_o_rs1idx     = ir[19:15];
  assign ifu.ifu_o_rs2idx     = ir[24:20];
  assign ifu.ifu_o_prdt_taken = prdt_taken;
  assign ifu.ifu_o_valid      = ir_valid;
  assign ifu.ifu_o_pc_vld     = ir_valid;
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus a randomized instruction stream
// checked against a next-PC model built from immediate values, not decoded bits.
module tb_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_rtvec, inspect_pc, rf2ifu_x1, rf2ifu_rs1;
  int          checks = 0, errors = 0;
  logic [31:0] cur;

  ifu_fetch_if ifu();

  ifu_fetch dut (
    .clk(clk), .rst(rst), .inspect_pc(inspect_pc), .pc_rtvec(pc_rtvec),
    .rf2ifu_x1(rf2ifu_x1), .rf2ifu_rs1(rf2ifu_rs1), .ifu(ifu)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, 3'b000, rd, op};
  endfunction

  // memory side of one fetch; optionally drops o_ready as the response lands
  task automatic fetch(input logic [31:0] instr, input bit stall, output logic [31:0] rpc, output bit to);
    int n = 0;
    to = 0;
    rpc = 'x;
    while (!ifu.ifu_req_valid && n < 50) begin @(negedge clk); n++; end
    if (!ifu.ifu_req_valid) begin to = 1; return; end
    rpc = ifu.ifu_req_pc;
    ifu.ifu_req_ready = 1;
    @(negedge clk);
    ifu.ifu_req_ready = 0;
    ifu.ifu_rsp_valid = 1;
    ifu.ifu_rsp_instr = instr;
    n = 0;
    while (!ifu.ifu_rsp_ready && n < 50) begin @(negedge clk); n++; end
    if (!ifu.ifu_rsp_ready) begin to = 1; ifu.ifu_rsp_valid = 0; return; end
    if (stall) ifu.ifu_o_ready = 0;
    @(negedge clk);
    ifu.ifu_rsp_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1; pc_rtvec = 32'h8000_0000;
    ifu.ifu_req_ready = 1; ifu.ifu_o_ready = 1; ifu.ifu_rsp_valid = 0; ifu.ifu_rsp_instr = '0;
    rf2ifu_x1 = '0; rf2ifu_rs1 = '0;
    repeat (3) @(negedge clk);
    checks++; if (ifu.ifu_o_valid !== 1'b0) begin errors++; $display("FAIL rst_o_valid got %b exp 0", ifu.ifu_o_valid); end
    checks++; if (ifu.ifu_o_pc_vld !== 1'b0) begin errors++; $display("FAIL rst_pc_vld got %b exp 0", ifu.ifu_o_pc_vld); end
    checks++; if (ifu.ifu_req_valid !== 1'b1) begin errors++; $display("FAIL rst_req_valid got %b exp 1", ifu.ifu_req_valid); end
    checks++; if (ifu.ifu_rsp_ready !== 1'b0) begin errors++; $display("FAIL rst_rsp_ready got %b exp 0", ifu.ifu_rsp_ready); end
    checks++; if (ifu.ifu_o_ir !== 32'h0) begin errors++; $display("FAIL rst_ir got %h exp 0", ifu.ifu_o_ir); end
    checks++; if (ifu.ifu_o_prdt_taken !== 1'b0) begin errors++; $display("FAIL rst_prdt got %b exp 0", ifu.ifu_o_prdt_taken); end
    checks++; if (inspect_pc !== 32'h8000_0000) begin errors++; $display("FAIL rst_inspect_pc got %h exp 80000000", inspect_pc); end
    rst = 0; ifu.ifu_req_ready = 0;
    @(negedge clk);
    checks++; if (ifu.ifu_req_pc !== 32'h8000_0000) begin errors++; $display("FAIL first_req_pc got %h exp 80000000", ifu.ifu_req_pc); end
  endtask

  task automatic test_sequential();
    logic [31:0] rpc; bit to;
    fetch(32'h0010_0093, 0, rpc, to);
    checks++; if (to) begin errors++; $display("FAIL seq_timeout got timeout exp handshake"); end
    checks++; if (rpc !== 32'h8000_0000) begin errors++; $display("FAIL seq_req_pc got %h exp 80000000", rpc); end
    checks++; if (ifu.ifu_o_valid !== 1'b1 || ifu.ifu_o_pc_vld !== 1'b1) begin errors++; $display("FAIL seq_valid got %b/%b exp 1/1", ifu.ifu_o_valid, ifu.ifu_o_pc_vld); end
    checks++; if (ifu.ifu_o_ir !== 32'h0010_0093) begin errors++; $display("FAIL seq_ir got %h exp 00100093", ifu.ifu_o_ir); end
    checks++; if (ifu.ifu_o_pc !== 32'h8000_0000) begin errors++; $display("FAIL seq_o_pc got %h exp 80000000", ifu.ifu_o_pc); end
    checks++; if (ifu.ifu_o_prdt_taken !== 1'b0) begin errors++; $display("FAIL seq_prdt got %b exp 0", ifu.ifu_o_prdt_taken); end
    checks++; if (ifu.ifu_o_rs1idx !== 5'd0 || ifu.ifu_o_rs2idx !== 5'd1) begin errors++; $display("FAIL seq_rsidx got %0d/%0d exp 0/1", ifu.ifu_o_rs1idx, ifu.ifu_o_rs2idx); end
    checks++; if (ifu.ifu_req_pc !== 32'h8000_0004) begin errors++; $display("FAIL seq_next_pc got %h exp 80000004", ifu.ifu_req_pc); end
  endtask

  task automatic test_jal();
    logic [31:0] rpc; bit to;
    fetch(enc_j(5'd1, 32'd16), 0, rpc, to);
    checks++; if (to || rpc !== 32'h8000_0004) begin errors++; $display("FAIL jal_req_pc got %h exp 80000004", rpc); end
    checks++; if (ifu.ifu_req_pc !== 32'h8000_0014) begin errors++; $display("FAIL jal_next_pc got %h exp 80000014", ifu.ifu_req_pc); end
    checks++; if (ifu.ifu_o_prdt_taken !== 1'b1) begin errors++; $display("FAIL jal_prdt got %b exp 1", ifu.ifu_o_prdt_taken); end
  endtask

  task automatic test_branch();
    logic [31:0] rpc; bit to;
    fetch(enc_j(5'd0, 32'hEC), 0, rpc, to);
    fetch(enc_b(-32'sd8, 5'd1, 5'd2), 0, rpc, to);
    checks++; if (to || rpc !== 32'h8000_0100) begin errors++; $display("FAIL bwd_req_pc got %h exp 80000100", rpc); end
    checks++; if (ifu.ifu_req_pc !== 32'h8000_00F8) begin errors++; $display("FAIL bwd_next_pc got %h exp 800000f8", ifu.ifu_req_pc); end
    checks++; if (ifu.ifu_o_prdt_taken !== 1'b1) begin errors++; $display("FAIL bwd_prdt got %b exp 1", ifu.ifu_o_prdt_taken); end
    fetch(enc_j(5'd0, 32'd8), 0, rpc, to);
    fetch(enc_b(32'd8, 5'd3, 5'd4), 0, rpc, to);
    checks++; if (to || rpc !== 32'h8000_0100) begin errors++; $display("FAIL fwd_req_pc got %h exp 80000100", rpc); end
    checks++; if (ifu.ifu_req_pc !== 32'h8000_0104) begin errors++; $display("FAIL fwd_next_pc got %h exp 80000104", ifu.ifu_req_pc); end
    checks++; if (ifu.ifu_o_prdt_taken !== 1'b0) begin errors++; $display("FAIL fwd_prdt got %b exp 0", ifu.ifu_o_prdt_taken); end
  endtask

  task automatic test_jalr();
    logic [31:0] rpc; bit to;
    rf2ifu_x1 = 32'h8000_0201; rf2ifu_rs1 = 32'hDEAD_BEEF;
    fetch(enc_i(32'd0, 5'd1, 5'd0, 7'b1100111), 1, rpc, to);
    checks++; if (to || rpc !== 32'h8000_0104) begin errors++; $display("FAIL jalr_req_pc got %h exp 80000104", rpc); end
    checks++; if (ifu.ifu_o_prdt_taken !== 1'b1) begin errors++; $display("FAIL jalr_prdt got %b exp 1", ifu.ifu_o_prdt_taken); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (ifu.ifu_req_valid !== 1'b0 || ifu.ifu_o_valid !== 1'b1) begin errors++; $display("FAIL jalr_stall%0d req/o_valid got %b/%b exp 0/1", i, ifu.ifu_req_valid, ifu.ifu_o_valid); end
      @(negedge clk);
    end
    ifu.ifu_o_ready = 1;
    @(negedge clk);
    checks++; if (ifu.ifu_req_valid !== 1'b1 || ifu.ifu_req_pc !== 32'h8000_0200) begin errors++; $display("FAIL jalr_target got %b/%h exp 1/80000200", ifu.ifu_req_valid, ifu.ifu_req_pc); end
    checks++; if (ifu.ifu_o_valid !== 1'b0) begin errors++; $display("FAIL jalr_consumed got %b exp 0", ifu.ifu_o_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rpc; bit to;
    logic [31:0] a, b;
    a = enc_i(32'd5, 5'd2, 5'd3, 7'b0010011);
    b = enc_i(32'd7, 5'd4, 5'd5, 7'b0010011);
    fetch(a, 1, rpc, to);
    checks++; if (to || rpc !== 32'h8000_0200) begin errors++; $display("FAIL bp_req_pc got %h exp 80000200", rpc); end
    ifu.ifu_req_ready = 1;
    @(negedge clk);
    ifu.ifu_req_ready = 0;
    ifu.ifu_rsp_valid = 1; ifu.ifu_rsp_instr = b;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ifu.ifu_rsp_ready !== 1'b0) begin errors++; $display("FAIL bp_rsp_ready%0d got %b exp 0", i, ifu.ifu_rsp_ready); end
      checks++; if (ifu.ifu_o_ir !== a || ifu.ifu_o_pc !== 32'h8000_0200) begin errors++; $display("FAIL bp_ir_stable%0d got %h@%h exp %h@80000200", i, ifu.ifu_o_ir, ifu.ifu_o_pc, a); end
      @(negedge clk);
    end
    ifu.ifu_o_ready = 1;
    #1;
    checks++; if (ifu.ifu_rsp_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", ifu.ifu_rsp_ready); end
    @(negedge clk);
    ifu.ifu_rsp_valid = 0;
    checks++; if (ifu.ifu_o_ir !== b || ifu.ifu_o_pc !== 32'h8000_0204 || ifu.ifu_o_valid !== 1'b1) begin errors++; $display("FAIL bp_load_wins got %h@%h v%b exp %h@80000204 v1", ifu.ifu_o_ir, ifu.ifu_o_pc, ifu.ifu_o_valid, b); end
    checks++; if (ifu.ifu_req_pc !== 32'h8000_0208) begin errors++; $display("FAIL bp_next_pc got %h exp 80000208", ifu.ifu_req_pc); end
  endtask

  task automatic test_reset_mid();
    ifu.ifu_req_ready = 1;
    @(negedge clk);
    ifu.ifu_req_ready = 0;
    ifu.ifu_rsp_valid = 1; ifu.ifu_rsp_instr = 32'h0000_006F;
    rst = 1; pc_rtvec = 32'h0000_1000;
    @(negedge clk);
    checks++; if (ifu.ifu_o_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_o_valid got %b exp 0", ifu.ifu_o_valid); end
    checks++; if (ifu.ifu_req_valid !== 1'b1 || ifu.ifu_req_pc !== 32'h0000_1000) begin errors++; $display("FAIL mid_rst_req got %b/%h exp 1/00001000", ifu.ifu_req_valid, ifu.ifu_req_pc); end
    checks++; if (ifu.ifu_rsp_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_rsp_ready got %b exp 0", ifu.ifu_rsp_ready); end
    rst = 0; ifu.ifu_rsp_valid = 0;
  endtask

  task automatic test_random();
    logic [6:0] ops [7] = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111, 7'b1110011};
    logic [31:0] instr, rpc, expn, r, base;
    logic [4:0]  rs1;
    bit to, ep, stall;
    int kind, v, sel, k;
    cur = 32'h0000_1000;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      r = $urandom;
      case (kind)
        0: begin instr = {r[31:7], ops[$urandom_range(0, 6)]}; expn = cur + 32'd4; ep = 0; end
        1: begin v = (int'($urandom_range(0, 1048575)) - 524288) * 2; instr = enc_j(r[4:0], v); expn = cur + v; ep = 1; end
        2: begin
          v = (int'($urandom_range(0, 4095)) - 2048) * 2; instr = enc_b(v, r[4:0], r[9:5]);
          ep = (v < 0); expn = ep ? cur + v : cur + 32'd4;
        end
        default: begin
          v = int'($urandom_range(0, 4095)) - 2048;
          sel = $urandom_range(0, 2);
          rs1 = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd1 : 5'($urandom_range(2, 31));
          rf2ifu_x1 = $urandom; rf2ifu_rs1 = $urandom;
          base = (sel == 0) ? 32'd0 : (sel == 1) ? rf2ifu_x1 : rf2ifu_rs1;
          instr = enc_i(v, rs1, r[4:0], 7'b1100111);
          expn = (base + v) & 32'hFFFF_FFFE; ep = 1;
        end
      endcase
      stall = (kind == 3) || ($urandom_range(0, 1) == 1);
      fetch(instr, stall, rpc, to);
      checks++; if (to || rpc !== cur) begin errors++; $display("FAIL rnd%0d_req_pc got %h exp %h", i, rpc, cur); end
      checks++; if (ifu.ifu_o_ir !== instr || ifu.ifu_o_pc !== cur) begin errors++; $display("FAIL rnd%0d_ir got %h@%h exp %h@%h", i, ifu.ifu_o_ir, ifu.ifu_o_pc, instr, cur); end
      checks++; if (ifu.ifu_o_prdt_taken !== ep) begin errors++; $display("FAIL rnd%0d_prdt got %b exp %b", i, ifu.ifu_o_prdt_taken, ep); end
      checks++; if (ifu.ifu_o_rs1idx !== instr[19:15] || ifu.ifu_o_rs2idx !== instr[24:20]) begin errors++; $display("FAIL rnd%0d_rsidx got %0d/%0d", i, ifu.ifu_o_rs1idx, ifu.ifu_o_rs2idx); end
      k = stall ? $urandom_range(1, 3) : 0;
      for (int j = 0; j < k; j++) begin
        checks++; if (ifu.ifu_o_valid !== 1'b1 || ifu.ifu_req_valid !== (kind != 3)) begin errors++; $display("FAIL rnd%0d_hold got v%b req%b exp v1 req%b", i, ifu.ifu_o_valid, ifu.ifu_req_valid, kind != 3); end
        @(negedge clk);
      end
      ifu.ifu_o_ready = 1;
      @(negedge clk);
      checks++; if (ifu.ifu_o_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_consume got %b exp 0", i, ifu.ifu_o_valid); end
      checks++; if (ifu.ifu_req_valid !== 1'b1 || ifu.ifu_req_pc !== expn) begin errors++; $display("FAIL rnd%0d_next_pc got %b/%h exp 1/%h", i, ifu.ifu_req_valid, ifu.ifu_req_pc, expn); end
      cur = expn;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jal();
    test_branch();
    test_jalr();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
